// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/baud encodings, 16x divisor helper and receiver FSM states.
// The transmitter imports this same package so both ends agree on every encoding.
package uart_pkg;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  function automatic int unsigned baud_hz(input logic [1:0] sel);
    case (sel)
      BAUD_2400:  return 2400;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      default:    return 19200;
    endcase
  endfunction

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [1:0] sel,
                                           input int unsigned oversample = 16);
    return clk_freq / (baud_hz(sel) * oversample);
  endfunction

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, phase reset by restart.
// tick is combinational from the counter so the first tick lands exactly DIV clocks after restart drops.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [1:0] baud_rate,
  output logic       tick
);

  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_2400, OVERSAMPLE);
  localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CW-1:0] TOP_2400  = CW'(baud_div(CLK_FREQ, BAUD_2400,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] TOP_4800  = CW'(baud_div(CLK_FREQ, BAUD_4800,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] TOP_9600  = CW'(baud_div(CLK_FREQ, BAUD_9600,  OVERSAMPLE) - 1);
  localparam logic [CW-1:0] TOP_19200 = CW'(baud_div(CLK_FREQ, BAUD_19200, OVERSAMPLE) - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] top;

  always_comb begin
    top = TOP_19200;
    case (baud_rate)
      BAUD_2400: top = TOP_2400;
      BAUD_4800: top = TOP_4800;
      BAUD_9600: top = TOP_9600;
      default:   top = TOP_19200;
    endcase
  end

  assign tick = !restart && (cnt == top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == top)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8N1 with optional odd/even parity, one-clock valid strobe.
// Handshake: valid is a one-clock strobe with no back-pressure; data_out/parity_err/frame_err change only on valid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active,
  output rx_state_t  fsm_state
);

  rx_state_t  state, state_next;
  logic       sync1, rx_s, rx_prev;
  logic [1:0] baud_q, par_q;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic       tick;
  logic       restart, load;
  logic       start_edge, mid_start, bit_done;
  logic       par_expect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_rx_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .baud_rate(baud_q),
    .tick     (tick)
  );

  assign start_edge = rx_prev && !rx_s;
  assign mid_start  = tick && (tick_cnt == 4'd7);
  assign bit_done   = tick && (tick_cnt == 4'd15);
  assign par_expect = (par_q == PAR_EVEN) ? (^shift) : ~(^shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_edge) state_next = ST_START;
      ST_START:  if (mid_start) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && (bit_cnt == 3'd7))
                   state_next = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_next = ST_STOP;
      ST_STOP:   if (bit_done) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    restart = (state == ST_IDLE);
    load    = (state == ST_STOP) && bit_done;
    active  = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  end

  assign fsm_state = state;

  // Sample counter re-zeroes at the start midpoint so later samples sit mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      baud_q   <= BAUD_2400;
      par_q    <= PAR_NONE;
    end else begin
      if (restart || ((state == ST_START) && mid_start) || bit_done) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end

      if (restart) begin
        bit_cnt <= '0;
      end else if ((state == ST_DATA) && bit_done) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {rx_s, shift[7:1]};
      end

      if ((state == ST_PARITY) && bit_done) begin
        par_bit <= rx_s;
      end

      if ((state == ST_IDLE) && start_edge) begin
        baud_q <= baud_rate;
        par_q  <= parity_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        data_out   <= shift;
        frame_err  <= !rx_s;
        parity_err <= parity_enabled(par_q) && (par_bit != par_expect);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand sequences for glitch, break and reset.
// Run at CLK_FREQ=2 MHz so frames stay short; divisors 52/26/13/6 for 2400/4800/9600/19200.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 2_000_000;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       active;
  rx_state_t  fsm_state;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud_rate  (baud_rate),
    .parity_type(parity_type),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .active     (active),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_t = 0;
  int cur_div = 1;
  int vcount = 0;
  logic active_seen = 1'b0;
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 52;
      2'b01:   return 26;
      2'b10:   return 13;
      default: return 6;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid must match the oldest expected frame and land mid stop bit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (active) active_seen = 1'b1;
      if (valid) begin
        logic [9:0] e;
        int lat;
        vcount++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - stop_t;
          chk("data_out", {24'd0, data_out}, {24'd0, e[9:2]});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e[1]});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e[0]});
          total++;
          if (lat < 8 * cur_div || lat > 16 * cur_div + 3) begin
            bad++;
            $display("FAIL latency: got %0d clks, required %0d..%0d", lat, 8 * cur_div, 16 * cur_div + 3);
          end
        end
      end
    end
  end

  task automatic hold_bit(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic sbit, input int bclks, input logic scramble);
    @(negedge clk);
    rx = 1'b0;
    hold_bit(bclks);
    if (scramble) begin
      baud_rate   = 2'b00;
      parity_type = 2'b10;
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_bit(bclks);
    end
    if (has_par) begin
      rx = pbit;
      hold_bit(bclks);
    end
    rx = sbit;
    stop_t = cyc;
    hold_bit(bclks);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("pending_frames", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [1:0] baud;
    logic [1:0] ptype;
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    int         bclks;
    int         gap;
    logic       scramble;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int v0;
    logic has_par;

    // baud ptype data pbit sbit bclks gap scramble exp_perr
    vecs[0] = '{2'b10, 2'b00, 8'hA5, 1'b0, 1'b1, 208, 100, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 2'b10, 8'hA5, 1'b0, 1'b1,  96, 100, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 2'b10, 8'hA5, 1'b1, 1'b1,  96, 100, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 2'b01, 8'hA5, 1'b1, 1'b1,  96, 100, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 2'b11, 8'h3C, 1'b0, 1'b1, 208, 100, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 2'b01, 8'h01, 1'b0, 1'b1, 832, 200, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 2'b00, 8'h96, 1'b0, 1'b1, 208, 100, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 2'b00, 8'h00, 1'b0, 1'b1, 408,   0, 1'b0, 1'b0};
    vecs[8] = '{2'b01, 2'b00, 8'hFF, 1'b0, 1'b1, 408,   0, 1'b0, 1'b0};
    vecs[9] = '{2'b01, 2'b00, 8'h55, 1'b0, 1'b1, 408, 100, 1'b0, 1'b0};

    rst_n = 1'b0;
    rx = 1'b1;
    baud_rate = 2'b10;
    parity_type = 2'b00;
    repeat (5) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      baud_rate   = vecs[k].baud;
      parity_type = vecs[k].ptype;
      cur_div     = div_of(vecs[k].baud);
      has_par     = (vecs[k].ptype == 2'b01) || (vecs[k].ptype == 2'b10);
      exp_q.push_back({vecs[k].data, vecs[k].exp_perr, ~vecs[k].sbit});
      send_frame(vecs[k].data, has_par, vecs[k].pbit, vecs[k].sbit, vecs[k].bclks, vecs[k].scramble);
      if (vecs[k].gap > 0) begin
        drain(20 * cur_div);
        hold_bit(vecs[k].gap);
        chk("idle_active", {31'd0, active}, 32'd0);
      end
    end
    chk("valid_count_table", vcount, 32'd10);

    // Glitch shorter than half a bit at 2400 baud.
    baud_rate = 2'b00;
    parity_type = 2'b00;
    cur_div = 52;
    v0 = vcount;
    active_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    hold_bit(200);
    rx = 1'b1;
    hold_bit(1000);
    chk("glitch_no_valid", vcount, v0);
    chk("glitch_no_active", {31'd0, active_seen}, 32'd0);
    chk("glitch_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});

    // Stop bit low followed by a held-low line: one frame, then BREAK.
    baud_rate = 2'b10;
    cur_div = 13;
    v0 = vcount;
    exp_q.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 208, 1'b0);
    hold_bit(3 * 208);
    chk("break_one_valid", vcount, v0 + 1);
    chk("break_state", {29'd0, fsm_state}, {29'd0, ST_BREAK});
    rx = 1'b1;
    hold_bit(208);
    chk("break_release_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    chk("break_no_extra_valid", vcount, v0 + 1);

    // Reset during data bit 4 of 0x81.
    v0 = vcount;
    @(negedge clk);
    rx = 1'b0;
    hold_bit(208);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      hold_bit(208);
    end
    rx = 1'b0;
    hold_bit(104);
    chk("mid_frame_active", {31'd0, active}, 32'd1);
    chk("pre_rst_data", {24'd0, data_out}, 32'h3C);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_out", {24'd0, data_out}, 32'd0);
    chk("async_rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("async_rst_active", {31'd0, active}, 32'd0);
    chk("async_rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    rx = 1'b1;
    hold_bit(20);
    rst_n = 1'b1;
    hold_bit(300);
    chk("abort_no_valid", vcount, v0);
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 208, 1'b0);
    drain(20 * cur_div);
    hold_bit(50);
    chk("after_rst_one_valid", vcount, v0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
